// File: rtl/axi_router_pkg.sv
// Shared definitions for the AXI 1-to-N address router: response codes,
// channel state encodings and the region match helper.
package axi_router_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_e;

  // True when addr and base agree on every bit at or above position 'bits'.
  // Both operands arrive zero-extended to 64 bits, so the upper padding
  // always compares equal.
  function automatic logic region_hit(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [31:0] bits);
    logic [63:0] diff;
    diff = addr ^ base;
    if (bits >= 32'd64) return 1'b1;
    return ((diff >> bits) == 64'd0);
  endfunction

endpackage

// File: rtl/axi_router_decoder.sv
// Address decoder: maps an address onto a one-hot slave select. The lowest
// matching index wins; writes that land on a read-only region are misses.
module axi_router_decoder
  import axi_router_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDR = {32'hF8000000, 32'hFFFE0000, 32'h0},
  parameter logic [NUM_SLAVES*32-1:0] REGION_BITS = {32'd12, 32'd16, 32'd14},
  parameter logic [NUM_SLAVES-1:0] WRITE_EN = 3'b101
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  is_write,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  miss
);

  logic found;

  // Priority search over the regions; the first match decides hit or miss.
  always_comb begin
    sel   = '0;
    miss  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!found && region_hit(64'(addr),
                               64'(BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]),
                               REGION_BITS[i*32 +: 32])) begin
        found = 1'b1;
        if (!is_write || WRITE_EN[i]) begin
          sel[i] = 1'b1;
          miss   = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/axi_addr_router_1xn.sv
// AXI4 1-to-N address router. One upstream master is routed to one of
// NUM_SLAVES downstream slaves by address. Misses (unmapped, or writes to
// read-only regions) are answered locally with DECERR and reported through
// err_addr/err_valid/decerr_count.
module axi_addr_router_1xn
  import axi_router_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDR = {32'hF8000000, 32'hFFFE0000, 32'h0},
  parameter logic [NUM_SLAVES*32-1:0] REGION_BITS = {32'd12, 32'd16, 32'd14},
  parameter logic [NUM_SLAVES-1:0] WRITE_EN = 3'b101
) (
  input  logic                             clk,
  input  logic                             rst_n,
  // upstream write address
  input  logic [ADDR_WIDTH-1:0]            s_axi_awaddr,
  input  logic [7:0]                       s_axi_awlen,
  input  logic [2:0]                       s_axi_awsize,
  input  logic [1:0]                       s_axi_awburst,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  // upstream write data
  input  logic [DATA_WIDTH-1:0]            s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s_axi_wstrb,
  input  logic                             s_axi_wlast,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  // upstream write response
  output logic [1:0]                       s_axi_bresp,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  // upstream read address
  input  logic [ADDR_WIDTH-1:0]            s_axi_araddr,
  input  logic [7:0]                       s_axi_arlen,
  input  logic [2:0]                       s_axi_arsize,
  input  logic [1:0]                       s_axi_arburst,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  // upstream read data
  output logic [DATA_WIDTH-1:0]            s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rlast,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  // downstream write address
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [NUM_SLAVES*8-1:0]          m_axi_awlen,
  output logic [NUM_SLAVES*3-1:0]          m_axi_awsize,
  output logic [NUM_SLAVES*2-1:0]          m_axi_awburst,
  output logic [NUM_SLAVES-1:0]            m_axi_awvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_awready,
  // downstream write data
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] m_axi_wdata,
  output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic [NUM_SLAVES-1:0]            m_axi_wlast,
  output logic [NUM_SLAVES-1:0]            m_axi_wvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_wready,
  // downstream write response
  input  logic [NUM_SLAVES*2-1:0]          m_axi_bresp,
  input  logic [NUM_SLAVES-1:0]            m_axi_bvalid,
  output logic [NUM_SLAVES-1:0]            m_axi_bready,
  // downstream read address
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [NUM_SLAVES*8-1:0]          m_axi_arlen,
  output logic [NUM_SLAVES*3-1:0]          m_axi_arsize,
  output logic [NUM_SLAVES*2-1:0]          m_axi_arburst,
  output logic [NUM_SLAVES-1:0]            m_axi_arvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_arready,
  // downstream read data
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [NUM_SLAVES*2-1:0]          m_axi_rresp,
  input  logic [NUM_SLAVES-1:0]            m_axi_rlast,
  input  logic [NUM_SLAVES-1:0]            m_axi_rvalid,
  output logic [NUM_SLAVES-1:0]            m_axi_rready,
  // decode error reporting
  output logic [ADDR_WIDTH-1:0]            err_addr,
  output logic                             err_valid,
  input  logic                             err_ack,
  output logic [15:0]                      decerr_count
);

  // ---------------------------------------------------------------- write side
  w_state_e                w_state, w_state_next;
  logic                    aw_rdy;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [7:0]              aw_len_q;
  logic [2:0]              aw_size_q;
  logic [1:0]              aw_burst_q;
  logic [NUM_SLAVES-1:0]   aw_sel_q;
  logic                    aw_miss_q;
  logic [NUM_SLAVES-1:0]   aw_dec_sel;
  logic                    aw_dec_miss;
  logic                    aw_hs;

  // ----------------------------------------------------------------- read side
  r_state_e                r_state, r_state_next;
  logic                    ar_rdy;
  logic [ADDR_WIDTH-1:0]   ar_addr_q;
  logic [7:0]              ar_len_q;
  logic [2:0]              ar_size_q;
  logic [1:0]              ar_burst_q;
  logic [NUM_SLAVES-1:0]   ar_sel_q;
  logic                    ar_miss_q;
  logic [NUM_SLAVES-1:0]   ar_dec_sel;
  logic                    ar_dec_miss;
  logic                    ar_hs;
  logic [7:0]              beat_cnt;
  logic                    r_last_beat;

  // ------------------------------------------------------------ error report
  logic                    w_miss_hs;
  logic                    r_miss_hs;
  logic [1:0]              miss_inc;
  logic [16:0]             cnt_sum;

  axi_router_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .REGION_BITS(REGION_BITS),
    .WRITE_EN   (WRITE_EN)
  ) u_aw_dec (
    .addr    (s_axi_awaddr),
    .is_write(1'b1),
    .sel     (aw_dec_sel),
    .miss    (aw_dec_miss)
  );

  axi_router_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .REGION_BITS(REGION_BITS),
    .WRITE_EN   (WRITE_EN)
  ) u_ar_dec (
    .addr    (s_axi_araddr),
    .is_write(1'b0),
    .sel     (ar_dec_sel),
    .miss    (ar_dec_miss)
  );

  // awready/arready are registered so they sit at 0 through reset and rise
  // one cycle after release.
  assign s_axi_awready = aw_rdy;
  assign s_axi_arready = ar_rdy;
  assign aw_hs         = s_axi_awvalid && aw_rdy;
  assign ar_hs         = s_axi_arvalid && ar_rdy;
  assign w_miss_hs     = aw_hs && aw_dec_miss;
  assign r_miss_hs     = ar_hs && ar_dec_miss;
  assign r_last_beat   = (beat_cnt == ar_len_q);

  // Address/control fields are broadcast; only the selected valid is raised.
  assign m_axi_awaddr  = {NUM_SLAVES{aw_addr_q}};
  assign m_axi_awlen   = {NUM_SLAVES{aw_len_q}};
  assign m_axi_awsize  = {NUM_SLAVES{aw_size_q}};
  assign m_axi_awburst = {NUM_SLAVES{aw_burst_q}};
  assign m_axi_wdata   = {NUM_SLAVES{s_axi_wdata}};
  assign m_axi_wstrb   = {NUM_SLAVES{s_axi_wstrb}};
  assign m_axi_wlast   = {NUM_SLAVES{s_axi_wlast}};
  assign m_axi_araddr  = {NUM_SLAVES{ar_addr_q}};
  assign m_axi_arlen   = {NUM_SLAVES{ar_len_q}};
  assign m_axi_arsize  = {NUM_SLAVES{ar_size_q}};
  assign m_axi_arburst = {NUM_SLAVES{ar_burst_q}};

  // Write FSM state, upstream AW ready and the decoded route.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      aw_rdy    <= 1'b0;
      aw_sel_q  <= '0;
      aw_miss_q <= 1'b0;
    end else begin
      w_state <= w_state_next;
      aw_rdy  <= (w_state_next == W_IDLE);
      if (aw_hs) begin
        aw_sel_q  <= aw_dec_sel;
        aw_miss_q <= aw_dec_miss;
      end
    end
  end

  // Captured AW fields replayed towards the selected slave.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      aw_addr_q  <= s_axi_awaddr;
      aw_len_q   <= s_axi_awlen;
      aw_size_q  <= s_axi_awsize;
      aw_burst_q <= s_axi_awburst;
    end
  end

  // Write FSM next state and channel steering.
  always_comb begin
    w_state_next  = w_state;
    m_axi_awvalid = '0;
    m_axi_wvalid  = '0;
    m_axi_bready  = '0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = AXI_RESP_OKAY;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) w_state_next = aw_dec_miss ? W_DATA : W_ADDR;
      end
      W_ADDR: begin
        m_axi_awvalid = aw_sel_q;
        if (|(m_axi_awready & aw_sel_q)) w_state_next = W_DATA;
      end
      W_DATA: begin
        if (aw_miss_q) begin
          s_axi_wready = 1'b1;
        end else begin
          m_axi_wvalid = aw_sel_q & {NUM_SLAVES{s_axi_wvalid}};
          s_axi_wready = |(m_axi_wready & aw_sel_q);
        end
        if (s_axi_wvalid && s_axi_wready && s_axi_wlast) w_state_next = W_RESP;
      end
      W_RESP: begin
        if (aw_miss_q) begin
          s_axi_bvalid = 1'b1;
          s_axi_bresp  = AXI_RESP_DECERR;
        end else begin
          m_axi_bready = aw_sel_q & {NUM_SLAVES{s_axi_bready}};
          s_axi_bvalid = |(m_axi_bvalid & aw_sel_q);
          for (int i = 0; i < NUM_SLAVES; i++) begin
            if (aw_sel_q[i]) s_axi_bresp = m_axi_bresp[2*i +: 2];
          end
        end
        if (s_axi_bvalid && s_axi_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Read FSM state, upstream AR ready and the decoded route.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      ar_rdy    <= 1'b0;
      ar_sel_q  <= '0;
      ar_miss_q <= 1'b0;
    end else begin
      r_state <= r_state_next;
      ar_rdy  <= (r_state_next == R_IDLE);
      if (ar_hs) begin
        ar_sel_q  <= ar_dec_sel;
        ar_miss_q <= ar_dec_miss;
      end
    end
  end

  // Captured AR fields replayed towards the selected slave.
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      ar_addr_q  <= s_axi_araddr;
      ar_len_q   <= s_axi_arlen;
      ar_size_q  <= s_axi_arsize;
      ar_burst_q <= s_axi_arburst;
    end
  end

  // Beat counter for locally generated DECERR read bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (ar_hs) begin
      beat_cnt <= '0;
    end else if (r_state == R_DATA && ar_miss_q && s_axi_rready && !r_last_beat) begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  // Read FSM next state and channel steering.
  always_comb begin
    r_state_next  = r_state;
    m_axi_arvalid = '0;
    m_axi_rready  = '0;
    s_axi_rvalid  = 1'b0;
    s_axi_rdata   = '0;
    s_axi_rresp   = AXI_RESP_OKAY;
    s_axi_rlast   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) r_state_next = ar_dec_miss ? R_DATA : R_ADDR;
      end
      R_ADDR: begin
        m_axi_arvalid = ar_sel_q;
        if (|(m_axi_arready & ar_sel_q)) r_state_next = R_DATA;
      end
      R_DATA: begin
        if (ar_miss_q) begin
          s_axi_rvalid = 1'b1;
          s_axi_rresp  = AXI_RESP_DECERR;
          s_axi_rlast  = r_last_beat;
        end else begin
          m_axi_rready = ar_sel_q & {NUM_SLAVES{s_axi_rready}};
          s_axi_rvalid = |(m_axi_rvalid & ar_sel_q);
          for (int i = 0; i < NUM_SLAVES; i++) begin
            if (ar_sel_q[i]) begin
              s_axi_rdata = m_axi_rdata[i*DATA_WIDTH +: DATA_WIDTH];
              s_axi_rresp = m_axi_rresp[2*i +: 2];
              s_axi_rlast = m_axi_rlast[i];
            end
          end
        end
        if (s_axi_rvalid && s_axi_rready && s_axi_rlast) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign miss_inc = {1'b0, w_miss_hs} + {1'b0, r_miss_hs};
  assign cnt_sum  = {1'b0, decerr_count} + {15'd0, miss_inc};

  // Sticky error capture (write wins a tie) and saturating DECERR count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr     <= '0;
      err_valid    <= 1'b0;
      decerr_count <= '0;
    end else begin
      if (w_miss_hs || r_miss_hs) begin
        if (!err_valid || err_ack) err_addr <= w_miss_hs ? s_axi_awaddr : s_axi_araddr;
        err_valid <= 1'b1;
      end else if (err_ack) begin
        err_valid <= 1'b0;
      end
      decerr_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

endmodule

// File: doc/axi_addr_router_1xn.md
Name: axi_addr_router_1xn

Overview:
Parametrised AXI4 1-to-N address router for the SoC fabric. It connects one CPU-side master to NUM_SLAVES memory-mapped slaves (RAM, ROM, Citron, LSIC, ...). Each slave has a configurable base address, region size and write permission. Unmapped accesses and writes to read-only regions are terminated internally with DECERR, and the faulting address is captured for the interrupt controller.

Parameters:
NUM_SLAVES, 3, number of downstream slave ports (1..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
BASE_ADDR, {32'hF8000000,32'hFFFE0000,32'h0}, concatenated per-slave base addresses, slave 0 in the LSBs
REGION_BITS, {32'd12,32'd16,32'd14}, per-slave log2 of region size; slave i matches when addr[ADDR_WIDTH-1:REGION_BITS[i]] == BASE_ADDR[i][ADDR_WIDTH-1:REGION_BITS[i]]
WRITE_EN, 3'b101, per-slave write permission; 0 means the slave is read-only

Ports:
clk  in  1  single clock
rst_n  in  1  reset, asynchronous assert, active-low
s_axi_aw{addr,len,size,burst,valid} / s_axi_awready  in/out  ADDR_WIDTH,8,3,2,1 / 1  upstream write address
s_axi_w{data,strb,last,valid} / s_axi_wready  in/out  DATA_WIDTH,DATA_WIDTH/8,1,1 / 1  upstream write data
s_axi_b{resp,valid} / s_axi_bready  out/in  2,1 / 1  upstream write response
s_axi_ar{addr,len,size,burst,valid} / s_axi_arready  in/out  as AW  upstream read address
s_axi_r{data,resp,last,valid} / s_axi_rready  out/in  DATA_WIDTH,2,1,1 / 1  upstream read data
m_axi_aw{addr,len,size,burst,valid} / m_axi_awready  out/in  NUM_SLAVES× each field  flattened downstream AW
m_axi_w{data,strb,last,valid} / m_axi_wready  out/in  NUM_SLAVES× each field  downstream W
m_axi_b{resp,valid} / m_axi_bready  in/out  NUM_SLAVES× each field  downstream B
m_axi_ar{addr,len,size,burst,valid} / m_axi_arready  out/in  NUM_SLAVES× each field  downstream AR
m_axi_r{data,resp,last,valid} / m_axi_rready  in/out  NUM_SLAVES× each field  downstream R
err_addr  out  ADDR_WIDTH  address of the first unacknowledged decode error
err_valid  out  1  sticky error flag
err_ack  in  1  clears err_valid
decerr_count  out  16  saturating count of DECERR transactions

Behaviour:
- Reset (async, rst_n=0): all valids and readys are 0; FSMs go to IDLE; err_valid=0, err_addr=0, decerr_count=0. Reset mid-burst abandons the transaction with no drain.
- Decode: combinational, from the address only. If several regions match, the lowest index wins. No match, or a write to a slave with WRITE_EN[i]=0, is a miss.
- Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: s_awready=1. AW handshake registers the AW fields, the slave index and the miss flag.
  - W_ADDR: drives m_awvalid[sel] with the registered fields until m_awready[sel]. On a miss, skips directly to W_DATA.
  - W_DATA: combinational pass-through s_w* <-> m_w*[sel]. On a miss, s_wready=1 and beats are discarded. Leaves on the beat with wlast.
  - W_RESP: passes m_b*[sel] through. On a miss, drives bvalid with bresp=2'b11 until bready.
  - Minimum latency: AW accept to m_awvalid = 1 cycle.
- Read FSM (independent of write, runs concurrently): R_IDLE -> R_ADDR -> R_DATA -> R_IDLE. Structure mirrors the write FSM.
  - R_DATA hit: pass-through; exits on the r handshake with rlast=1.
  - R_DATA miss: emits arlen+1 beats with rdata=0, rresp=2'b11 and rlast on the final beat, using an 8-bit beat counter. Beats advance only on s_rready.
- Non-selected m_*valid and m_*ready outputs are held at 0 at all times.
- Error capture happens at the AW/AR handshake of a miss.
  - If err_valid=0, latch err_addr and set err_valid.
  - Simultaneous read and write misses: the write address is captured.
  - err_ack clears err_valid. If a new miss arrives in the same cycle, it is captured and err_valid stays 1.
  - decerr_count increments by 1, or by 2 for a simultaneous read and write miss, and saturates at 16'hFFFF.

Decomposition:
- Package axi_router_pkg holds: AXI_RESP_OKAY=2'b00 and AXI_RESP_DECERR=2'b11; the write and read state enums; and a function region_hit(addr, base, bits).
- One sub-module, axi_router_decoder, parametrised like the parent. It takes an address and is_write, and returns a one-hot select and a miss flag. It is instantiated once for AW and once for AR.

Test Plan:
- Single read at 0x0000_0010, len=0, slave 0 returns 0xDEADBEEF -> m_arvalid[0] one cycle after AR accept; upstream rdata=0xDEADBEEF, rresp=00, rlast=1.
- Write burst of 4 beats to 0xF800_0004 -> only slave 2 sees AW/W; wlast appears on beat 4; bresp=00 is forwarded.
- Write to ROM 0xFFFE_0000 with len=1 -> no m_awvalid; both W beats accepted; bresp=11; err_addr=0xFFFE_0000; err_valid=1; decerr_count=1.
- Read at unmapped 0x4000_0000 with len=3, with rready toggling -> exactly 4 beats, each rdata=0 and rresp=11, rlast on the 4th beat only.
- Read and write misses in the same cycle -> err_addr equals the write address; decerr_count increases by 2. A later err_ack clears err_valid.
- rst_n deasserted mid read burst -> all valids drop asynchronously; after release a new read completes normally.
